// File: rtl/seg_pkg.sv
// Shared constants, digit encoding, FSM states and sizing helper for
// signed_seg_display. All segment patterns are active low, bit0=a .. bit6=g.
package seg_pkg;

  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    UPDATE = 2'd2
  } state_e;

  // BCD digit 0..9 to segment pattern; any other code shows blank.
  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // ceil(width*log10(2) + 1) in integer math; 0.30103 approximates log10(2)
  // and width*log10(2) is never an integer for width >= 1.
  function automatic int unsigned bcd_digits(input int unsigned width);
    return (width * 30103 + 199999) / 100000;
  endfunction

endpackage

// File: rtl/seg_decode.sv
// One seven-segment digit: BCD nibble plus blank flag to active-low pattern.
//   bcd_i   : BCD digit 0..9
//   blank_i : force the digit dark
//   seg_o   : active-low segments, bit0=a .. bit6=g
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  assign seg_o = blank_i ? SEG_BLANK : seg_encode(bcd_i);

endmodule

// File: rtl/signed_seg_display.sv
// Signed binary to multi-digit seven-segment converter using a sequential
// double-dabble engine. Displays hold the last result until the next done.
//   clk, rst : clock, synchronous active-high reset
//   start    : request a conversion (only honoured in IDLE)
//   value    : two's-complement operand, captured on accepted start
//   busy     : conversion in progress
//   done     : one-cycle pulse when seg/ovf update
//   ovf      : magnitude does not fit in DIGITS digits
//   seg      : digit d in seg[7d+6:7d], d=DIGITS is the sign digit
module signed_seg_display
  import seg_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DIGITS   = 3,
  parameter int unsigned LZ_BLANK = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [WIDTH-1:0]          value,
  output logic                      busy,
  output logic                      done,
  output logic                      ovf,
  output logic [7*(DIGITS+1)-1:0]   seg
);

  localparam int unsigned ND = bcd_digits(WIDTH);
  localparam int unsigned BW = 4 * ND;
  localparam int unsigned PD = (ND > DIGITS) ? ND : DIGITS;
  localparam int unsigned PW = 4 * PD;
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned SW = 7 * (DIGITS + 1);
  localparam int unsigned DW = 7 * DIGITS;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic             neg_q, neg_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic [SW-1:0]    seg_q, seg_d;

  logic [BW-1:0]    adj_c;
  logic [PW-1:0]    bcd_pad_c;
  logic [DIGITS-1:0] blank_c;
  logic             all_zero_c;
  logic             ovf_c;
  logic [DW-1:0]    dec_seg_c;
  logic [DW-1:0]    dig_seg_c;

  // Add-3 correction on every nibble >= 5 ahead of the shift.
  always_comb begin
    adj_c = bcd_q;
    for (int i = 0; i < int'(ND); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Zero-extend so every displayed digit has a nibble even when DIGITS > ND.
  assign bcd_pad_c = PW'(bcd_q);

  // Overflow: any nonzero nibble at or above position DIGITS.
  always_comb begin
    ovf_c = 1'b0;
    for (int i = int'(DIGITS); i < int'(PD); i++) begin
      if (bcd_pad_c[4*i +: 4] != 4'd0) ovf_c = 1'b1;
    end
  end

  // Leading-zero blanking, scanning down from the top displayed digit.
  always_comb begin
    blank_c    = '0;
    all_zero_c = 1'b1;
    for (int d = int'(DIGITS) - 1; d >= 0; d--) begin
      all_zero_c = all_zero_c && (bcd_pad_c[4*d +: 4] == 4'd0);
      blank_c[d] = (LZ_BLANK != 0) && (d != 0) && all_zero_c;
    end
  end

  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_dig
    seg_decode u_dec (
      .bcd_i   (bcd_pad_c[4*g +: 4]),
      .blank_i (blank_c[g]),
      .seg_o   (dec_seg_c[7*g +: 7])
    );
  end

  // Overflow replaces every magnitude digit with minus.
  always_comb begin
    dig_seg_c = dec_seg_c;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (ovf_c) dig_seg_c[7*d +: 7] = SEG_MINUS;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    neg_d   = neg_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    seg_d   = seg_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          // Negation of the most negative value wraps to 2^(WIDTH-1), which is exact unsigned.
          mag_d   = value[WIDTH-1] ? WIDTH'(~value + WIDTH'(1)) : value;
          neg_d   = value[WIDTH-1];
          bcd_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        bcd_d = BW'({adj_c, mag_q[WIDTH-1]});
        mag_d = {mag_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = UPDATE;
      end
      UPDATE: begin
        seg_d   = {(neg_q ? SEG_MINUS : SEG_BLANK), dig_seg_c};
        ovf_d   = ovf_c;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mag_q   <= '0;
      neg_q   <= 1'b0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      seg_q   <= '1;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      neg_q   <= neg_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      seg_q   <= seg_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign ovf  = ovf_q;
  assign seg  = seg_q;

endmodule

// File: tb/tb_signed_seg_display.sv
// Bench for signed_seg_display: three instances (blanking on, blanking off,
// two digits) share clock, reset, start and value.
module tb_signed_seg_display;

  localparam logic [6:0] MINUS = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] ENC [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  value = 8'd0;

  logic        busy_a, done_a, ovf_a;
  logic        busy_b, done_b, ovf_b;
  logic        busy_c, done_c, ovf_c;
  logic [27:0] seg_a, seg_b;
  logic [20:0] seg_c;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  signed_seg_display #(.WIDTH(8), .DIGITS(3), .LZ_BLANK(1)) u_a (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .busy(busy_a), .done(done_a), .ovf(ovf_a), .seg(seg_a));

  signed_seg_display #(.WIDTH(8), .DIGITS(3), .LZ_BLANK(0)) u_b (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .busy(busy_b), .done(done_b), .ovf(ovf_b), .seg(seg_b));

  signed_seg_display #(.WIDTH(8), .DIGITS(2), .LZ_BLANK(1)) u_c (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .busy(busy_c), .done(done_c), .ovf(ovf_c), .seg(seg_c));

  function automatic bit model_ovf(input int v, input int digs);
    int m, p;
    m = (v < 0) ? -v : v;
    p = 1;
    for (int i = 0; i < digs; i++) p *= 10;
    return m >= p;
  endfunction

  // Expected display from decimal arithmetic on |v|.
  function automatic logic [27:0] model_seg(input int v, input int digs, input bit lz);
    logic [27:0] r;
    int m, p;
    bit ov;
    m  = (v < 0) ? -v : v;
    ov = model_ovf(v, digs);
    r  = '1;
    p  = 1;
    for (int d = 0; d < digs; d++) begin
      if (ov)                       r[7*d +: 7] = MINUS;
      else if (lz && d > 0 && m < p) r[7*d +: 7] = BLANK;
      else                          r[7*d +: 7] = ENC[(m / p) % 10];
      p *= 10;
    end
    r[7*digs +: 7] = (v < 0) ? MINUS : BLANK;
    return r;
  endfunction

  // Launch one conversion, scramble value afterwards, wait (bounded) for done.
  task automatic run_convert(input int v, output int lat,
                             output logic [27:0] sa, output logic [27:0] sb,
                             output logic [20:0] sc,
                             output logic oa, output logic ob, output logic oc);
    @(negedge clk);
    start = 1'b1;
    value = 8'(v);
    @(posedge clk);
    #1;
    start = 1'b0;
    value = ~value;
    lat = 0;
    while (!done_a && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    sa = seg_a; sb = seg_b; sc = seg_c;
    oa = ovf_a; ob = ovf_b; oc = ovf_c;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy_a, done_a, ovf_a, busy_c, done_c, ovf_c} !== 6'b0)
      $display("FAIL reset_flags: got %b expected 000000", {busy_a, done_a, ovf_a, busy_c, done_c, ovf_c});
    else passed++;
    checks++;
    if (seg_a !== '1 || seg_b !== '1 || seg_c !== '1)
      $display("FAIL reset_seg: got %h %h %h expected all ones", seg_a, seg_b, seg_c);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Check all three instances against the model for one value.
  task automatic test_value(input string name, input int v);
    int lat;
    logic [27:0] sa, sb, ea, eb;
    logic [20:0] sc, ec;
    logic oa, ob, oc;
    logic [27:0] tmp;
    run_convert(v, lat, sa, sb, sc, oa, ob, oc);
    ea = model_seg(v, 3, 1'b1);
    eb = model_seg(v, 3, 1'b0);
    tmp = model_seg(v, 2, 1'b1);
    ec = tmp[20:0];
    checks++;
    if (lat !== 9) $display("FAIL %s_latency v=%0d: got %0d expected 9", name, v, lat);
    else passed++;
    checks++;
    if (sa !== ea) $display("FAIL %s_seg_lz v=%0d: got %b expected %b", name, v, sa, ea);
    else passed++;
    checks++;
    if (sb !== eb) $display("FAIL %s_seg_nolz v=%0d: got %b expected %b", name, v, sb, eb);
    else passed++;
    checks++;
    if (sc !== ec) $display("FAIL %s_seg_2dig v=%0d: got %b expected %b", name, v, sc, ec);
    else passed++;
    checks++;
    if ({oa, ob, oc} !== {model_ovf(v, 3), model_ovf(v, 3), model_ovf(v, 2)})
      $display("FAIL %s_ovf v=%0d: got %b expected %b", name, v, {oa, ob, oc},
               {model_ovf(v, 3), model_ovf(v, 3), model_ovf(v, 2)});
    else passed++;
  endtask

  task automatic test_directed();
    test_value("min_neg", -128);
    checks++;
    if (seg_a !== {MINUS, ENC[1], ENC[2], ENC[8]})
      $display("FAIL min_neg_literal: got %b expected %b", seg_a, {MINUS, ENC[1], ENC[2], ENC[8]});
    else passed++;
    test_value("five", 5);
    test_value("zero", 0);
    checks++;
    if (seg_a !== {BLANK, BLANK, BLANK, ENC[0]})
      $display("FAIL zero_literal: got %b expected %b", seg_a, {BLANK, BLANK, BLANK, ENC[0]});
    else passed++;
    test_value("seven", 7);
    checks++;
    if (seg_b !== {BLANK, ENC[0], ENC[0], ENC[7]})
      $display("FAIL seven_nolz_literal: got %b expected %b", seg_b, {BLANK, ENC[0], ENC[0], ENC[7]});
    else passed++;
    test_value("hundred", 100);
    checks++;
    if (seg_c !== {BLANK, MINUS, MINUS} || ovf_c !== 1'b1)
      $display("FAIL hundred_2dig_literal: got %b/%b expected %b/1", seg_c, ovf_c, {BLANK, MINUS, MINUS});
    else passed++;
    test_value("neg99", -99);
    test_value("max_pos", 127);
  endtask

  task automatic test_random();
    logic signed [7:0] b8;
    for (int i = 0; i < 30; i++) begin
      b8 = 8'($urandom_range(0, 255));
      test_value("random", int'(b8));
    end
  endtask

  // A second start mid-conversion must be ignored.
  task automatic test_ignore_start();
    int ndone;
    bit busy_ok;
    logic [27:0] got, exp;
    ndone = 0;
    busy_ok = 1'b1;
    got = '0;
    exp = model_seg(-45, 3, 1'b1);
    @(negedge clk);
    start = 1'b1;
    value = 8'(-45);
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 2) begin start = 1'b1; value = 8'd93; end
      if (i == 3) start = 1'b0;
      if (done_a) begin ndone++; got = seg_a; end
      if (i < 9 && !busy_a) busy_ok = 1'b0;
    end
    checks++;
    if (ndone !== 1) $display("FAIL ignore_done_count: got %0d expected 1", ndone);
    else passed++;
    checks++;
    if (got !== exp) $display("FAIL ignore_seg: got %b expected %b", got, exp);
    else passed++;
    checks++;
    if (!busy_ok || busy_a !== 1'b0) $display("FAIL ignore_busy: busy_ok=%0d busy=%b expected 1/0", busy_ok, busy_a);
    else passed++;
  endtask

  // Start during the UPDATE cycle is dropped; start in the done cycle is taken.
  task automatic test_back_to_back();
    int ndone;
    int lat;
    logic [27:0] exp1, exp2;
    exp1 = model_seg(61, 3, 1'b1);
    exp2 = model_seg(-3, 3, 1'b1);
    @(negedge clk);
    start = 1'b1;
    value = 8'd61;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    value = 8'd22;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (done_a !== 1'b1 || seg_a !== exp1)
      $display("FAIL update_start_done: got %b/%b expected 1/%b", done_a, seg_a, exp1);
    else passed++;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done_a || busy_a) ndone++;
    end
    checks++;
    if (ndone !== 0) $display("FAIL update_start_ignored: got %0d active cycles expected 0", ndone);
    else passed++;
    // value here is still 22 from above; run into done then restart immediately
    @(negedge clk);
    start = 1'b1;
    value = 8'd88;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    while (!done_a && lat < 40) begin @(posedge clk); #1; lat++; end
    start = 1'b1;
    value = 8'(-3);
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (busy_a !== 1'b1) $display("FAIL b2b_accept: busy got %b expected 1", busy_a);
    else passed++;
    lat = 0;
    while (!done_a && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat !== 9 || seg_a !== exp2)
      $display("FAIL b2b_result: got lat=%0d seg=%b expected lat=9 seg=%b", lat, seg_a, exp2);
    else passed++;
  endtask

  // Reset mid-conversion aborts without a done pulse.
  task automatic test_reset_mid();
    int ndone;
    @(negedge clk);
    start = 1'b1;
    value = 8'd77;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || seg_a !== '1)
      $display("FAIL reset_mid_state: got busy=%b done=%b seg=%b expected 0/0/all ones", busy_a, done_a, seg_a);
    else passed++;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (done_a || busy_a) ndone++;
    end
    checks++;
    if (ndone !== 0) $display("FAIL reset_mid_no_done: got %0d active cycles expected 0", ndone);
    else passed++;
    test_value("after_reset", -37);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/signed_seg_display.md
Name: signed_seg_display

Overview:
- Parametrised successor to the 4-bit signed single-digit seven-segment lookup.
- Converts a WIDTH-bit two's-complement value into DIGITS decimal digits plus a sign digit, all active-low seven-segment patterns.
- Uses a sequential shift-add-3 (double-dabble) engine with a start/busy/done handshake.
- Sits between the calculator datapath and the board HEX displays; display outputs hold the last result until a new conversion completes.

Parameters:
- WIDTH, 8, input value width in bits, two's complement, legal range 2..16.
- DIGITS, 3, number of decimal magnitude digits driven, legal range 1..5.
- LZ_BLANK, 1, when 1 leading zeros are blanked; when 0 all digits are shown.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active high.
- start  in  1  request to convert value; sampled only when idle.
- value  in  WIDTH  signed operand, captured on the accepted start.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when seg and ovf update.
- ovf  out  1  magnitude does not fit in DIGITS digits; holds until the next done.
- seg  out  7*(DIGITS+1)  digit d in seg[7d+6:7d]; d=0 is rightmost; d=DIGITS is the sign digit; bit0=a … bit6=g, active low.

Behaviour:
- Reset: synchronous, active high. On the clk edge with rst=1: busy=0, done=0, ovf=0, all seg bits=1 (all digits blank), FSM→IDLE.
- Reset mid-conversion aborts the conversion; no done pulse is produced.
- Encodings: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, minus=0111111, blank=1111111.
- FSM states: IDLE, CONV, UPDATE.
- IDLE: on start=1 at edge k, capture mag = |value| as an unsigned WIDTH-bit value and neg = value[WIDTH-1]; clear the BCD accumulator; busy=1 from edge k; →CONV.
- Magnitude of the most negative value: -2^(WIDTH-1) gives mag = 2^(WIDTH-1), which is exact (e.g. -128 → 128). No saturation.
- CONV: one double-dabble iteration per cycle. Each iteration adds 3 to every BCD nibble ≥5, then shifts left one bit with the mag MSB entering.
  - Exactly WIDTH iterations, at edges k+1 .. k+WIDTH.
  - Accumulator width: 4*ceil(WIDTH*log10(2)+1) bits, enough to never drop a bit.
  - After the last iteration →UPDATE.
- UPDATE (edge k+WIDTH+1): register seg and ovf, done=1 for exactly one cycle, busy=0, →IDLE. Total latency is WIDTH+1 cycles from the start edge.
- ovf=1 iff mag ≥ 10^DIGITS. When ovf=1, every magnitude digit shows minus and the sign digit follows neg.
- Sign digit: minus if neg, else blank.
- LZ_BLANK=1: magnitude digits above the most significant nonzero digit are blank; digit 0 is never blanked, so value 0 shows "0".
- start while busy=1 is ignored; no queueing.
- start on the UPDATE cycle is ignored. start on the cycle after done is accepted.
- value changing after acceptance has no effect on the result in progress.
- seg is stable between done pulses. There is no intermediate glitching on seg during CONV.

Decomposition:
- Package seg_pkg holds:
  - localparams SEG_MINUS and SEG_BLANK;
  - the 10-entry digit encoding function/constant array;
  - FSM state enum {IDLE, CONV, UPDATE};
  - a function computing the required BCD digit count from WIDTH.
- One combinational sub-module, seg_decode (4-bit BCD in, blank flag in, 7-bit seg out), instantiated DIGITS times in a generate loop.
- Double-dabble engine, FSM and blanking logic stay in the top module.

Test Plan:
1. WIDTH=8, DIGITS=3: rst, then start with value=-128 (8'h80) → done exactly 9 cycles after the start edge; sign=0111111, digits "128" (1111001, 0100100, 0000000), ovf=0.
2. LZ_BLANK=1, value=5 → sign and digits 2,1 = 1111111, digit0=0010010. value=0 → digit0=1000000, all others blank.
3. LZ_BLANK=0, value=7 → digits "007" (1000000, 1000000, 1111000), sign blank.
4. WIDTH=8, DIGITS=2, value=100 → ovf=1, both digits 0111111, sign blank. Then value=-99 → ovf=0, minus "99".
5. Pulse start again 3 cycles into a conversion with a different value → ignored: single done, first value displayed, busy continuous.
6. Assert rst at cycle 4 of a conversion → next cycle busy=0, seg all ones, no done. Then a fresh start converts normally.
